// File: rtl/pipe_skid_stage.sv
// Two-entry pipeline skid stage: main entry drives the outputs, skid absorbs one extra beat.
// Latency: 1 cycle from accept to out_* when EMPTY or ONE-with-pop; strict FIFO order.
// Backpressure: in_ready is purely registered (low only when FULL); flush squashes all entries.
//
// Ports:
//   clk, rst                 - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready        - upstream handshake; in_data (LANES*DATA_W, lane 0 in LSBs), in_ctrl
//   out_valid/out_ready      - downstream handshake; out_data, out_ctrl (zero when out_valid=0)
//   flush                    - drop every held entry and any same-cycle input
//   clr_cnt, stall_cnt       - saturating count of cycles with out_valid=1 and out_ready=0
module pipe_skid_stage #(
  parameter int LANES  = 3,
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]       out_ctrl,
  input  logic                    clr_cnt,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int PW = LANES * DATA_W;

  typedef struct packed {
    logic [PW-1:0]     dat;
    logic [CTRL_W-1:0] ctl;
  } ent_t;

  ent_t             main_q, main_d;
  ent_t             skid_q, skid_d;
  ent_t             in_ent;
  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             pop;

  // The skid entry is only ever valid behind a valid main entry, so
  // FULL is exactly "skid valid" and in_ready needs nothing else.
  assign in_ready  = ~skid_vld_q;
  assign accept    = in_valid & in_ready;
  assign pop       = main_vld_q & out_ready;
  assign in_ent    = {in_data, in_ctrl};

  assign out_valid = main_vld_q;
  assign out_data  = main_q.dat;
  assign out_ctrl  = main_vld_q ? main_q.ctl : '0;
  assign stall_cnt = cnt_q;

  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    if (flush) begin
      // Payload registers are left untouched; only the valid bits drop.
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      main_vld_d = accept | skid_vld_q | (main_vld_q & ~pop);
      skid_vld_d = skid_vld_q ? ~pop : (accept & main_vld_q & ~pop);
      // accept is impossible while FULL, so the two main sources never collide.
      if (skid_vld_q && pop) begin
        main_d = skid_q;
      end else if (accept && (!main_vld_q || pop)) begin
        main_d = in_ent;
      end
      if (accept && main_vld_q && !pop) begin
        skid_d = in_ent;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (main_vld_q && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 LANES 3 : number of data lanes (e.g. ALU result, store data, PC+2)
 DATA_W 16 : width of each data lane
 CTRL_W 8 : width of control bundle (mem write/read, mem-to-reg, reg write, halt, dump, link, ...)
 CNT_W 16 : width of stall-cycle counter
REQ-002 Ports (name, direction, width, meaning), one per line:
 clk in 1 : single clock, all state on rising edge
 rst in 1 : asynchronous, active-low reset
 in_valid in 1 : upstream stage holds a valid instruction
 in_ready out 1 : stage can accept this cycle
 in_data in LANES*DATA_W : packed lane payload, lane 0 in LSBs
 in_ctrl in CTRL_W : control bundle
 flush in 1 : squash all held entries (branch/exception)
 out_valid out 1 : head entry valid
 out_ready in 1 : downstream accepts head
 out_data out LANES*DATA_W : head payload
 out_ctrl out CTRL_W : head control, forced zero when out_valid=0
 clr_cnt in 1 : synchronous clear of stall counter
 stall_cnt out CNT_W : cycles with out_valid=1 and out_ready=0

Function
REQ-003 Storage SHALL be two entries: main (drives outputs) and skid; each entry = data, ctrl, valid bit.
REQ-004 State SHALL be one of EMPTY (no valid), ONE (main only), FULL (main+skid); encoding free, derived from valid bits permitted.
REQ-005 in_ready SHALL be registered-derived: 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready or in_valid.
REQ-006 Accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-007 EMPTY: accept -> main<=input, ONE; else stay.
REQ-008 ONE: accept&pop -> main<=input, stay ONE; accept only -> skid<=input, FULL; pop only -> EMPTY; neither -> stay, main held.
REQ-009 FULL: pop -> main<=skid, skid invalid, ONE; else stay, both held.
REQ-010 Latency: an accepted entry SHALL appear on out_* the cycle after accept when the stage was EMPTY or ONE-with-pop; order SHALL be strictly FIFO.
REQ-011 Throughput: with out_ready held 1, one entry per cycle SHALL pass with no bubbles.
REQ-012 flush SHALL have priority over all transfers: next state EMPTY, both valid bits 0; an input offered the same cycle SHALL be dropped; a pop the same cycle still completes downstream.
REQ-013 out_ctrl SHALL be all zero whenever out_valid=0 (bubble injection); out_data SHALL hold the last main data (don't-care for checking).
REQ-014 Data/ctrl registers SHALL load only on accept or skid-to-main move; no load otherwise.
REQ-015 stall_cnt SHALL increment by 1 each cycle out_valid & ~out_ready, saturate at 2^CNT_W-1, never wrap.
REQ-016 clr_cnt SHALL zero stall_cnt next cycle, overriding a same-cycle increment.
REQ-017 All widths SHALL be parameter-derived; LANES>=1, DATA_W>=1, CTRL_W>=1, CNT_W>=2 supported.

Reset
REQ-018 rst low SHALL immediately (asynchronously) clear valid bits, data, ctrl and stall_cnt to zero; state EMPTY.
REQ-019 During and after reset: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0.
REQ-020 Reset asserted mid-transfer SHALL discard all entries; first post-reset accept behaves as from EMPTY.

Verification
REQ-021 Streaming: out_ready=1, push lane0=0x0001..0x0008 on 8 consecutive cycles -> same values emerge 1 cycle later, in order, out_valid continuous, in_ready always 1.
REQ-022 Backpressure: out_ready=0, push 0xAAAA then 0xBBBB -> in_ready=0 after second accept, stall_cnt counts up; raise out_ready -> 0xAAAA then 0xBBBB on consecutive cycles, in_ready returns 1.
REQ-023 Flush in FULL with in_valid=1 (0xCCCC) -> next cycle out_valid=0, out_ctrl=0, in_ready=1, 0xCCCC never appears.
REQ-024 Saturation: CNT_W=2, out_valid=1, out_ready=0 for 6 cycles -> stall_cnt 1,2,3,3,3,3; clr_cnt pulse -> 0.
REQ-025 Async reset: drop rst between clock edges while FULL -> out_valid, stall_cnt, out_ctrl go 0 without waiting for clk; in_ready=1.
